// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 receiver shared types and scan-code prefixes
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

endpackage

// File: rtl/ps2_sync_filter.sv
// rtl/ps2_sync_filter.sv - 2-flop synchronizer with optional PS2_RX_GLITCH_FILTER_EN glitch filter (din in, dout out)
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [1:0] sync_q;

    // Idle PS/2 lines float high, so the synchronizer resets to 1.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

`ifdef PS2_RX_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [CW-1:0] cnt_q;
    logic          filt_q;

    // The output flips on the FILTER_LEN-th consecutive sample that
    // disagrees with it; any agreeing sample restarts the run.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else if (sync_q[1] == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
            filt_q <= sync_q[1];
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign dout = filt_q;
`else
    assign dout = sync_q[1];
`endif

endmodule

// File: rtl/ps2_rx_ctrl.sv
// rtl/ps2_rx_ctrl.sv - PS/2 keyboard frame receiver and scan-code decoder (optional PS2_RX_GLITCH_FILTER_EN)
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       kb_clk,
    input  logic       kb_data,
    output logic [7:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_break,
    output logic       key_ext,
    output logic       err_parity,
    output logic       overrun
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          kb_clk_c;
    logic          kb_data_c;
    logic          kb_clk_prev_q;
    logic          fall;

    ps2_state_t    state_q;
    ps2_state_t    state_d;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    sreg_q;
    logic          parity_q;
    logic [TW-1:0] tmo_cnt_q;
    logic          break_pend_q;
    logic          ext_pend_q;

    logic          frame_done;
    logic          frame_good;
    logic          frame_bad;
    logic          tmo_hit;
    logic          key_load;

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .sys_clk (sys_clk),
        .reset   (reset),
        .din     (kb_clk),
        .dout    (kb_clk_c)
    );

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .sys_clk (sys_clk),
        .reset   (reset),
        .din     (kb_data),
        .dout    (kb_data_c)
    );

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            kb_clk_prev_q <= 1'b1;
        end else begin
            kb_clk_prev_q <= kb_clk_c;
        end
    end

    assign fall = kb_clk_prev_q & ~kb_clk_c;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        tmo_hit    = (state_q != ST_IDLE) && !fall && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
        case (state_q)
            ST_IDLE: begin
                if (fall && !kb_data_c) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (fall && (bit_cnt_q == 3'd7)) begin
                    state_d = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (tmo_hit) begin
            state_d = ST_IDLE;
        end
    end

    // Odd parity: data bits and parity bit together hold an odd count of ones.
    assign frame_good = frame_done && kb_data_c && (^{sreg_q, parity_q});
    assign frame_bad  = frame_done && !frame_good;
    assign key_load   = frame_good && (sreg_q != PS2_BREAK) && (sreg_q != PS2_EXT);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q <= '0;
            sreg_q    <= '0;
            parity_q  <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            if (state_q != ST_DATA) begin
                bit_cnt_q <= '0;
            end else if (fall) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end

            if ((state_q == ST_DATA) && fall) begin
                sreg_q <= {kb_data_c, sreg_q[7:1]};
            end

            if ((state_q == ST_PARITY) && fall) begin
                parity_q <= kb_data_c;
            end

            if ((state_q == ST_IDLE) || fall || tmo_hit) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            break_pend_q <= 1'b0;
            ext_pend_q   <= 1'b0;
        end else if (frame_bad || key_load) begin
            break_pend_q <= 1'b0;
            ext_pend_q   <= 1'b0;
        end else if (frame_good) begin
            if (sreg_q == PS2_BREAK) begin
                break_pend_q <= 1'b1;
            end
            if (sreg_q == PS2_EXT) begin
                ext_pend_q <= 1'b1;
            end
        end
    end

    // One-deep output register; a same-cycle handshake frees the slot so a
    // new key can load straight in behind the departing one.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            key_code   <= '0;
            key_valid  <= 1'b0;
            key_break  <= 1'b0;
            key_ext    <= 1'b0;
            err_parity <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            err_parity <= frame_bad;
            overrun    <= 1'b0;
            if (key_load) begin
                if (!key_valid || key_ready) begin
                    key_code  <= sreg_q;
                    key_break <= break_pend_q;
                    key_ext   <= ext_pend_q;
                    key_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// tb/tb_ps2_rx_ctrl.sv - self-checking bench for ps2_rx_ctrl
module tb_ps2_rx_ctrl;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 1000;
    localparam int HALF        = 20;

    logic       sys_clk   = 1'b0;
    logic       reset     = 1'b1;
    logic       kb_clk    = 1'b1;
    logic       kb_data   = 1'b1;
    logic       key_ready = 1'b1;
    logic [7:0] key_code;
    logic       key_valid;
    logic       key_break;
    logic       key_ext;
    logic       err_parity;
    logic       overrun;

    always #5 sys_clk = ~sys_clk;

    ps2_rx_ctrl #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .kb_clk     (kb_clk),
        .kb_data    (kb_data),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_break  (key_break),
        .key_ext    (key_ext),
        .err_parity (err_parity),
        .overrun    (overrun)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    int         checked     = 0;
    int         err_cnt     = 0;
    int         ovr_cnt     = 0;
    int         stable_viol = 0;
    int         exp_err     = 0;
    int         exp_ovr     = 0;
    logic       m_break     = 1'b0;
    logic       m_ext       = 1'b0;
    logic       prev_hold   = 1'b0;
    logic [9:0] prev_out    = '0;

    always @(negedge sys_clk) begin
        if (!reset) begin
            if (key_valid && key_ready) got_q.push_back({key_code, key_break, key_ext});
            if (err_parity) err_cnt <= err_cnt + 1;
            if (overrun) ovr_cnt <= ovr_cnt + 1;
            if (prev_hold && (!key_valid || ({key_code, key_break, key_ext} !== prev_out)))
                stable_viol <= stable_viol + 1;
        end
        prev_hold <= key_valid && !key_ready && !reset;
        prev_out  <= {key_code, key_break, key_ext};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_err++;
            m_break = 1'b0;
            m_ext   = 1'b0;
        end else if (b == 8'hF0) begin
            m_break = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            exp_q.push_back({b, m_break, m_ext});
            m_break = 1'b0;
            m_ext   = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                              input int nbits, input int glitch_bit);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            kb_data = bits[i];
            wait_cyc(HALF);
            if (i == glitch_bit) begin
                kb_clk = 1'b0;
                wait_cyc(FILTER_LEN - 1);
                kb_clk = 1'b1;
                wait_cyc(HALF);
            end
            kb_clk = 1'b0;
            wait_cyc(HALF);
            kb_clk = 1'b1;
        end
        kb_data = 1'b1;
        wait_cyc(2 * HALF);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11, -1);
        model_byte(b, 1'b1);
    endtask

    task automatic check_state(input string tag);
        int n;
        wait_cyc(40);
        chk({tag, " keys"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = checked; i < n; i++) chk({tag, " key"}, got_q[i], exp_q[i]);
        checked = n;
        chk({tag, " err_parity"}, err_cnt, exp_err);
        chk({tag, " overrun"}, ovr_cnt, exp_ovr);
        chk({tag, " hold"}, stable_viol, 0);
    endtask

    initial begin
        logic [7:0] b;
        int         r;
        bit         flip;

        wait_cyc(5);
        chk("rst key_valid", key_valid, 0);
        chk("rst key_code", key_code, 0);
        chk("rst key_break", key_break, 0);
        chk("rst key_ext", key_ext, 0);
        chk("rst err_parity", err_parity, 0);
        chk("rst overrun", overrun, 0);
        reset = 1'b0;
        wait_cyc(5);

        send_good(8'h1C);
        check_state("basic 1C");

        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        send_good(8'h75);
        check_state("ext break 75");

        send_frame(8'h1C, 1'b1, 1'b0, 11, -1);
        model_byte(8'h1C, 1'b0);
        send_good(8'h32);
        check_state("bad parity");

        send_good(8'hF0);
        send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
        model_byte(8'h1C, 1'b0);
        send_good(8'h1C);
        check_state("bad stop");

        key_ready = 1'b0;
        send_good(8'h1C);
        send_good(8'h32);
        void'(exp_q.pop_back());
        exp_ovr++;
        wait_cyc(20);
        chk("ovr key_valid", key_valid, 1);
        chk("ovr key_code", key_code, 8'h1C);
        key_ready = 1'b1;
        wait_cyc(2);
        chk("ovr drained", key_valid, 0);
        check_state("overrun");

        send_frame(8'h55, 1'b0, 1'b0, 6, -1);
        wait_cyc(TIMEOUT_CYC + 100);
        check_state("timeout idle");
        send_good(8'h29);
        check_state("after timeout");

        send_good(8'hE0);
        send_frame(8'h1C, 1'b0, 1'b0, 4, -1);
        reset = 1'b1;
        wait_cyc(3);
        chk("midrst key_valid", key_valid, 0);
        reset = 1'b0;
        m_break = 1'b0;
        m_ext   = 1'b0;
        wait_cyc(3);
        send_good(8'h1C);
        check_state("mid reset");

`ifdef PS2_RX_GLITCH_FILTER_EN
        send_frame(8'h4B, 1'b0, 1'b0, 11, 3);
        model_byte(8'h4B, 1'b1);
        check_state("glitch");
`endif

        for (int k = 0; k < 24; k++) begin
            b = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 9);
            if (r < 2) b = 8'hF0;
            else if (r == 2) b = 8'hE0;
            flip = ($urandom_range(0, 7) == 0);
            send_frame(b, flip, 1'b0, 11, -1);
            model_byte(b, !flip);
        end
        check_state("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_rx_ctrl.md
PS2_RX_CTRL -- requirements
Module: ps2_rx_ctrl

Interface
REQ-001 Parameter FILTER_LEN, default 8: number of consecutive equal sys_clk samples required to accept a kb_clk level change.
REQ-002 Parameter TIMEOUT_CYC, default 10000: number of sys_clk cycles without a kb_clk falling edge that aborts a frame in progress.
REQ-003 Port sys_clk, input, 1: system clock; all state SHALL change on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port kb_clk, input, 1: PS/2 clock, asynchronous to sys_clk.
REQ-006 Port kb_data, input, 1: PS/2 data, asynchronous to sys_clk.
REQ-007 Port key_code, output, 8: scan code of the decoded key.
REQ-008 Port key_valid, output, 1: key_code, key_break and key_ext are valid.
REQ-009 Port key_ready, input, 1: consumer accepts the key; transfer occurs when key_valid && key_ready.
REQ-010 Port key_break, output, 1: key release (code was preceded by 8'hF0).
REQ-011 Port key_ext, output, 1: extended key (code was preceded by 8'hE0).
REQ-012 Port err_parity, output, 1: one-cycle pulse on a parity or stop-bit error.
REQ-013 Port overrun, output, 1: one-cycle pulse when a decoded key is dropped because the output register is full.

Function
REQ-014 kb_clk and kb_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-015 Bits SHALL be sampled from the synchronized kb_data on the cycle a kb_clk falling edge is detected (1->0 of the conditioned kb_clk).
REQ-016 Frame FSM states SHALL be IDLE, DATA, PARITY and STOP.
REQ-017 IDLE: on a falling edge with data=0, go to DATA with bit_cnt=0; on a falling edge with data=1, stay in IDLE.
REQ-018 DATA: shift in 8 bits LSB first; after the 8th bit go to PARITY.
REQ-019 PARITY: capture the parity bit, then go to STOP.
REQ-020 STOP: the frame is good if stop=1 and the XOR of the 8 data bits and parity =1 (odd parity); then return to IDLE.
REQ-021 A bad frame SHALL pulse err_parity for 1 cycle, discard the byte, and clear the break/ext pending flags.
REQ-022 Timeout: in any non-IDLE state, after TIMEOUT_CYC cycles without a falling edge, return to IDLE, discard the partial frame, and raise no error.
REQ-023 Good byte 8'hF0: set break_pend; produce no output.
REQ-024 Good byte 8'hE0: set ext_pend; produce no output.
REQ-025 Any other good byte: present {code, break_pend, ext_pend}, then clear both pending flags.
REQ-026 A decoded key SHALL reach the outputs, with key_valid=1, exactly 1 cycle after the stop-bit sample cycle.
REQ-027 Outputs SHALL be held stable while key_valid && !key_ready.
REQ-028 key_valid SHALL clear on the cycle after the handshake, unless a new key loads in that same cycle, in which case it stays 1 with the new data.
REQ-029 A key decoded while key_valid && !key_ready SHALL be dropped, pulse overrun for 1 cycle, and leave the held key unchanged.
REQ-030 A decoded key SHALL be accepted whenever key_ready=1 in the same cycle (1-deep buffer with pass-through refill).

Reset
REQ-031 Reset SHALL force FSM=IDLE, bit_cnt=0, shift register=0, pending flags=0, timeout counter=0 and filter state=1 (idle-high bus).
REQ-032 Reset SHALL force key_code=0, key_valid=0, key_break=0, key_ext=0, err_parity=0 and overrun=0.
REQ-033 Reset asserted mid-frame SHALL abort the frame; the first frame after deassertion SHALL decode correctly.

Configuration
REQ-034 With PS2_RX_GLITCH_FILTER_EN defined, conditioned kb_clk SHALL change only after FILTER_LEN consecutive equal synchronized samples.
REQ-035 Without PS2_RX_GLITCH_FILTER_EN, conditioned kb_clk SHALL be the 2-flop synchronizer output, and FILTER_LEN SHALL be unused.

Structure
REQ-036 Package ps2_pkg SHALL hold the FSM state typedef, PS2_BREAK=8'hF0 and PS2_EXT=8'hE0.
REQ-037 Sub-module ps2_sync_filter (synchronizer plus optional glitch filter, one instance per PS/2 line) SHALL be used.

Verification
REQ-038 Frame 8'h1C, odd parity correct -> one key_valid pulse with key_code=8'h1C, break=0, ext=0; key_ready=1.
REQ-039 Sequence E0,F0,75 -> a single key: key_code=8'h75, break=1, ext=1; the following 8'h75 frame -> break=0, ext=0.
REQ-040 8'h1C with the parity bit flipped -> err_parity pulse, no key_valid; then 8'h32 -> decodes cleanly.
REQ-041 key_ready=0; send 8'h1C then 8'h32 -> 8'h1C held, overrun pulses once; key_ready=1 -> 8'h1C transferred, key_valid drops.
REQ-042 Stop kb_clk after 5 data bits for >TIMEOUT_CYC cycles -> IDLE, no outputs; the next 8'h29 frame decodes.
REQ-043 With PS2_RX_GLITCH_FILTER_EN defined, a kb_clk low glitch of FILTER_LEN-1 cycles mid-frame -> ignored, and the frame decodes correctly.
